// File: rtl/pc_fetch_unit.sv
// PC register + imem fetch sequencer (IDLE/REQ/WAIT/OUT/HALT); inst_valid_o 2 cycles after req with immediate gnt.
// Holds {pc, inst} while inst_ready_i is low. Define PC_MISALIGN_TRAP_EN to trap misaligned targets (else they are aligned down).
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              PC_INC       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            redirect_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misalign_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, HALT} state_t;

  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] inst, inst_d;
  logic [XLEN-1:0] redir_tgt, redir_tgt_d;
  logic            redir_pend, redir_pend_d;
  logic            load_en;
  logic [XLEN-1:0] load_pc;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [XLEN-1:0] RST_PC = RESET_VECTOR;
  logic misalign, misalign_d;
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] RST_PC = RESET_VECTOR & ALIGN_MASK;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RST_PC;
      inst       <= '0;
      redir_tgt  <= '0;
      redir_pend <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      inst       <= inst_d;
      redir_tgt  <= redir_tgt_d;
      redir_pend <= redir_pend_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign   <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    inst_d       = inst;
    redir_tgt_d  = redir_tgt;
    redir_pend_d = redir_pend;
    load_en      = 1'b0;
    load_pc      = next_pc_i;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d   = misalign;
`endif
    case (state)
      IDLE: begin
        state_d = REQ;
`ifdef PC_MISALIGN_TRAP_EN
        if (pc[1:0] != 2'b00) begin
          state_d    = HALT;
          misalign_d = 1'b1;
        end
`endif
      end
      REQ: begin
        // Address must stay stable mid-request, so a redirect is parked until the data returns.
        if (redirect_i) begin
          redir_tgt_d  = next_pc_i;
          redir_pend_d = 1'b1;
        end
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            load_en = 1'b1;
          end else if (redir_pend) begin
            load_en = 1'b1;
            load_pc = redir_tgt;
          end else begin
            inst_d  = imem_rdata_i;
            state_d = OUT;
          end
        end else if (redirect_i) begin
          redir_tgt_d  = next_pc_i;
          redir_pend_d = 1'b1;
        end
      end
      OUT: begin
        if (redirect_i) begin
          load_en = 1'b1;
        end else if (inst_ready_i) begin
          pc_d    = pc + INC;
          state_d = REQ;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      redir_pend_d = 1'b0;
      state_d      = REQ;
`ifdef PC_MISALIGN_TRAP_EN
      pc_d = load_pc;
      if (load_pc[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end
`else
      pc_d = load_pc & ALIGN_MASK;
`endif
    end
  end

  assign imem_req_o   = (state == REQ);
  assign imem_addr_o  = pc;
  assign inst_valid_o = (state == OUT);
  assign inst_o       = inst;
  assign pc_o         = pc;
  assign pc_plus4_o   = pc + INC;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_o   = misalign;
`else
  assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: per-cycle vector table for fetch/backpressure/redirect-on-accept,
// then hand sequences for redirect-while-pending, wrap, reset mid-op and misaligned targets.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc_i;
  logic        redirect_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        misalign_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .PC_INC(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .next_pc_i    (next_pc_i),
    .redirect_i   (redirect_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .misalign_o   (misalign_o)
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] npc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        chk;
    logic        e_req;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic rd, logic [31:0] np, logic g, logic v, logic [31:0] d,
                              logic y, logic c, logic eq, logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t t;
    t.rst = r;  t.redir = rd; t.npc = np; t.gnt = g; t.rv = v; t.rdata = d; t.rdy = y;
    t.chk = c;  t.e_req = eq; t.e_vld = ev; t.e_pc = ep; t.e_inst = ei;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; redirect_i = 1'b0; next_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0;
  endtask

  // Advance one cycle: next negedge, inputs back to idle, settle before sampling.
  task automatic next_cyc();
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // rst redir npc gnt rv rdata rdy | chk req vld pc inst
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 32'h0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 32'h0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hA000_0000, 0,  1, 0, 0, 32'h0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 32'h0, 32'hA000_0000));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 32'h4, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hA000_0001, 0,  1, 0, 0, 32'h4, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 32'h4, 32'hA000_0001));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 32'h8, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hA000_0002, 0,  1, 0, 0, 32'h8, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 32'h8, 32'hA000_0002));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 32'h8, 32'hA000_0002));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 32'hC, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hA000_0003, 0,  1, 0, 0, 32'hC, 0));
    vq.push_back(mk(0, 1, 32'h100, 0, 0, 0, 1,  1, 0, 1, 32'hC, 32'hA000_0003));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h100, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 32'h100, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'hA000_0004, 0,  1, 0, 0, 32'h100, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 32'h100, 32'hA000_0004));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h104, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; redirect_i = vq[i].redir; next_pc_i = vq[i].npc;
      imem_gnt_i = vq[i].gnt; imem_rvalid_i = vq[i].rv; imem_rdata_i = vq[i].rdata;
      inst_ready_i = vq[i].rdy;
      #1;
      if (vq[i].chk) begin
        chk($sformatf("v%0d req", i), imem_req_o, vq[i].e_req);
        chk($sformatf("v%0d vld", i), inst_valid_o, vq[i].e_vld);
        chk($sformatf("v%0d pc", i), pc_o, vq[i].e_pc);
        chk($sformatf("v%0d pc4", i), pc_plus4_o, vq[i].e_pc + 32'd4);
        chk($sformatf("v%0d mis", i), misalign_o, 1'b0);
        if (vq[i].e_req) chk($sformatf("v%0d addr", i), imem_addr_o, vq[i].e_pc);
        if (vq[i].e_vld) chk($sformatf("v%0d inst", i), inst_o, vq[i].e_inst);
        if (i == 1)      chk("rst inst", inst_o, 32'h0);
      end
    end

    // Redirect during WAIT with slow rvalid: data dropped, refetch at target.
    reset_dut();
    next_cyc();
    chk("t4 req0", imem_req_o, 1'b1);
    imem_gnt_i = 1'b1;
    next_cyc();
    redirect_i = 1'b1; next_pc_i = 32'h200;
    next_cyc();
    chk("t4 wait vld", inst_valid_o, 1'b0);
    next_cyc();
    chk("t4 wait vld2", inst_valid_o, 1'b0);
    next_cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    next_cyc();
    chk("t4 drop vld", inst_valid_o, 1'b0);
    chk("t4 req", imem_req_o, 1'b1);
    chk("t4 addr", imem_addr_o, 32'h200);

    // Redirect in REQ (address held), then another in WAIT: last one wins.
    redirect_i = 1'b1; next_pc_i = 32'h300;
    next_cyc();
    chk("t4b addr hold", imem_addr_o, 32'h200);
    chk("t4b req hold", imem_req_o, 1'b1);
    imem_gnt_i = 1'b1;
    next_cyc();
    redirect_i = 1'b1; next_pc_i = 32'h400;
    next_cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
    next_cyc();
    chk("t4b vld", inst_valid_o, 1'b0);
    chk("t4b addr", imem_addr_o, 32'h400);

    // Wrap: redirect to 0xFFFF_FFFC, accept, next fetch at 0.
    imem_gnt_i = 1'b1;
    next_cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
    next_cyc();
    chk("t5 vld", inst_valid_o, 1'b1);
    chk("t5 inst", inst_o, 32'h2222_2222);
    inst_ready_i = 1'b1; redirect_i = 1'b1; next_pc_i = 32'hFFFF_FFFC;
    next_cyc();
    chk("t5 pc top", pc_o, 32'hFFFF_FFFC);
    chk("t5 pc4 wrap", pc_plus4_o, 32'h0);
    imem_gnt_i = 1'b1;
    next_cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333;
    next_cyc();
    chk("t5 top vld", inst_valid_o, 1'b1);
    inst_ready_i = 1'b1;
    next_cyc();
    chk("t5 wrap req", imem_req_o, 1'b1);
    chk("t5 wrap addr", imem_addr_o, 32'h0);

    // Reset while in WAIT, then stale rvalid in IDLE and REQ.
    imem_gnt_i = 1'b1;
    next_cyc();
    rst = 1'b1;
    next_cyc();
    chk("t5 rst req", imem_req_o, 1'b0);
    chk("t5 rst vld", inst_valid_o, 1'b0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h4444_4444;
    next_cyc();
    chk("t5 idle stale req", imem_req_o, 1'b1);
    chk("t5 idle stale addr", imem_addr_o, 32'h0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5555_5555;
    next_cyc();
    chk("t5 req stale vld", inst_valid_o, 1'b0);
    chk("t5 req stale req", imem_req_o, 1'b1);
    chk("t5 inst clr", inst_o, 32'h0);

    // Redirect in OUT without accept: held instruction dropped.
    imem_gnt_i = 1'b1;
    next_cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h6666_6666;
    next_cyc();
    chk("t5 out vld", inst_valid_o, 1'b1);
    redirect_i = 1'b1; next_pc_i = 32'h500;
    next_cyc();
    chk("t5 drop vld", inst_valid_o, 1'b0);
    chk("t5 drop addr", imem_addr_o, 32'h500);

    // Misaligned redirect to 0x102.
    imem_gnt_i = 1'b1;
    next_cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h7777_7777;
    next_cyc();
    inst_ready_i = 1'b1; redirect_i = 1'b1; next_pc_i = 32'h102;
    next_cyc();
`ifdef PC_MISALIGN_TRAP_EN
    chk("t6 mis", misalign_o, 1'b1);
    chk("t6 pc", pc_o, 32'h102);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6 halt req%0d", k), imem_req_o, 1'b0);
      chk($sformatf("t6 halt vld%0d", k), inst_valid_o, 1'b0);
      imem_gnt_i = 1'b1;
      next_cyc();
    end
    chk("t6 mis sticky", misalign_o, 1'b1);
`else
    chk("t6 mis", misalign_o, 1'b0);
    chk("t6 req", imem_req_o, 1'b1);
    chk("t6 addr", imem_addr_o, 32'h100);
    imem_gnt_i = 1'b1;
    next_cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h8888_8888;
    next_cyc();
    chk("t6 vld", inst_valid_o, 1'b1);
    chk("t6 pc", pc_o, 32'h100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
